// File: rtl/lsu_if.sv
// Request/response channel between a requester and the load/store unit.
// One request is outstanding at a time; the response is a single-cycle pulse.
interface lsu_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/lsu.sv
// Byte-addressed RV32 load/store unit in front of a word-only memory.
// Sub-word stores are done as read-modify-write; faults never touch memory.
module lsu #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    lsu_if.slave                     bus,
    output logic                     mem_read_en_o,
    output logic [$clog2(DEPTH)-1:0] mem_read_pos_o,
    input  logic [31:0]              mem_read_data_i,
    input  logic                     mem_read_valid_i,
    output logic                     mem_write_en_o,
    output logic [$clog2(DEPTH)-1:0] mem_write_pos_o,
    output logic [31:0]              mem_write_data_o
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_we;
    logic          r_uns;
    logic          r_err;
    logic [1:0]    r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;

    logic          w_accept;
    logic          w_req_err;
    logic [PW-1:0] w_pos;
    logic [4:0]    w_shamt;
    logic [31:0]   w_lane;
    logic [31:0]   w_mask;
    logic [31:0]   w_load;
    logic [31:0]   w_merged;

    assign w_accept  = bus.req_valid_i && (r_state == IDLE);
    assign w_req_err = (bus.req_size_i == 2'b11)
                    || ((bus.req_size_i == 2'b01) && bus.req_addr_i[0])
                    || ((bus.req_size_i == 2'b10) && (bus.req_addr_i[1:0] != 2'b00))
                    || ({2'b00, bus.req_addr_i[31:2]} >= 32'(DEPTH));

    assign w_pos    = r_addr[PW+1:2];
    assign w_shamt  = {r_addr[1:0], 3'b000};
    assign w_lane   = mem_read_data_i >> w_shamt;
    assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shamt;
    assign w_merged = (mem_read_data_i & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

    always_comb begin
        w_load = mem_read_data_i;
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
            default: w_load = mem_read_data_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory-side outputs decode from state and latched fields only, never from req_*.
    always_comb begin
        w_next           = r_state;
        bus.req_ready_o  = 1'b0;
        bus.rsp_valid_o  = 1'b0;
        bus.rsp_rdata_o  = 32'd0;
        bus.rsp_err_o    = 1'b0;
        mem_read_en_o    = 1'b0;
        mem_read_pos_o   = '0;
        mem_write_en_o   = 1'b0;
        mem_write_pos_o  = '0;
        mem_write_data_o = 32'd0;
        case (r_state)
            IDLE: begin
                bus.req_ready_o = rst_ni;
                if (bus.req_valid_i) begin
                    if (w_req_err)
                        w_next = RESP;
                    else if (bus.req_we_i && (bus.req_size_i == 2'b10))
                        w_next = WRITE;
                    else
                        w_next = READ;
                end
            end
            READ: begin
                mem_read_en_o  = 1'b1;
                mem_read_pos_o = w_pos;
                w_next         = WAIT;
            end
            WAIT: begin
                if (mem_read_valid_i)
                    w_next = r_we ? WRITE : RESP;
            end
            WRITE: begin
                mem_write_en_o   = 1'b1;
                mem_write_pos_o  = w_pos;
                mem_write_data_o = r_wdata;
                w_next           = RESP;
            end
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                bus.rsp_rdata_o = r_rdata;
                bus.rsp_err_o   = r_err;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_wdata doubles as the merged word for sub-word stores, so WRITE always sends r_wdata.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= bus.req_we_i;
            r_uns   <= bus.req_unsigned_i;
            r_err   <= w_req_err;
            r_size  <= bus.req_size_i;
            r_addr  <= bus.req_addr_i;
            r_wdata <= bus.req_wdata_i;
            r_rdata <= 32'd0;
        end else if ((r_state == WAIT) && mem_read_valid_i) begin
            if (r_we)
                r_wdata <= w_merged;
            else
                r_rdata <= w_load;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array reference model, per-cycle compare process,
// and directed vectors with hand-computed literal results.
module tb_lsu;
    localparam int NONE = -100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memReadEn;
    logic [3:0]  memReadPos;
    logic [31:0] memReadData;
    logic        memReadValid;
    logic        memWriteEn;
    logic [3:0]  memWritePos;
    logic [31:0] memWriteData;

    lsu_if bus();

    lsu #(.DEPTH(16)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .bus              (bus),
        .mem_read_en_o    (memReadEn),
        .mem_read_pos_o   (memReadPos),
        .mem_read_data_i  (memReadData),
        .mem_read_valid_i (memReadValid),
        .mem_write_en_o   (memWriteEn),
        .mem_write_pos_o  (memWritePos),
        .mem_write_data_o (memWriteData)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached memory: whole-word storage, read data returned 'lat' cycles after the read enable.
    logic [31:0] mem [16];
    int          lat = 1;
    int          rdCnt = 0;
    logic [3:0]  rdPos = 4'd0;
    logic        memValidQ = 1'b0;
    logic [31:0] memDataQ = 32'd0;
    logic        spur = 1'b0;

    assign memReadValid = memValidQ | spur;
    assign memReadData  = spur ? 32'hDEAD_BEEF : memDataQ;

    always @(posedge clk) begin
        memValidQ <= 1'b0;
        if (memReadEn) begin
            if (lat <= 1) begin
                memValidQ <= 1'b1;
                memDataQ  <= mem[memReadPos];
            end else begin
                rdCnt <= lat - 1;
                rdPos <= memReadPos;
            end
        end else if (rdCnt > 0) begin
            rdCnt <= rdCnt - 1;
            if (rdCnt == 1) begin
                memValidQ <= 1'b1;
                memDataQ  <= mem[rdPos];
            end
        end
        if (memWriteEn) mem[memWritePos] <= memWriteData;
    end

    int gmem [64];
    bit          active = 1'b0;
    int          base = 0;
    int          readAt = NONE;
    int          writeAt = NONE;
    int          respAt = NONE;
    logic [31:0] expRdata = 32'd0;
    logic [31:0] expWdata = 32'd0;
    logic [3:0]  expPos = 4'd0;
    bit          expErr = 1'b0;

    logic [31:0] gotRdata = 32'd0;
    logic [31:0] gotWdata = 32'd0;
    logic        gotErr = 1'b0;
    int          respCount = 0;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got 0x%08h want 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [31:0] wordOf(input int w);
        logic [31:0] r;
        r = 32'd0;
        for (int j = 0; j < 4; j++) r = r | (32'(gmem[4*w+j]) << (8*j));
        return r;
    endfunction

    // Every cycle out of reset: enables, positions, data and response against the model's timetable.
    always @(negedge clk) begin
        int c;
        if (!rst_n) begin
            checkOutput("resetCtrl", 32'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                                          memReadEn, memWriteEn, memReadPos, memWritePos}), 32'd0);
            checkOutput("resetRdata", bus.rsp_rdata_o, 32'd0);
            checkOutput("resetWdata", memWriteData, 32'd0);
        end else begin
            c = active ? (cyc - base) : (NONE - 1);
            checkOutput("ready", 32'(bus.req_ready_o), 32'(!active));
            checkOutput("readEn", 32'(memReadEn), 32'(c == readAt));
            checkOutput("readPos", 32'(memReadPos), (c == readAt) ? 32'(expPos) : 32'd0);
            checkOutput("writeEn", 32'(memWriteEn), 32'(c == writeAt));
            checkOutput("writePos", 32'(memWritePos), (c == writeAt) ? 32'(expPos) : 32'd0);
            checkOutput("writeData", memWriteData, (c == writeAt) ? expWdata : 32'd0);
            if (memWriteEn) gotWdata = memWriteData;
            checkOutput("rspValid", 32'(bus.rsp_valid_o), 32'(c == respAt));
            if (bus.rsp_valid_o) begin
                checkOutput("rspRdata", bus.rsp_rdata_o, expRdata);
                checkOutput("rspErr", 32'(bus.rsp_err_o), 32'(expErr));
                gotRdata = bus.rsp_rdata_o;
                gotErr   = bus.rsp_err_o;
                respCount++;
            end
        end
    end

    // Builds the expected timetable and results from the byte-level model, then hands the request over.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, input bit commit);
        int          idx;
        int          n;
        logic [31:0] v;
        bit          err;
        err = (size == 2'd3) || ((size == 2'd1) && (addr % 2 != 0))
           || ((size == 2'd2) && (addr % 4 != 0)) || (addr >= 32'd64);
        readAt = NONE; writeAt = NONE; respAt = NONE;
        expRdata = 32'd0; expWdata = 32'd0; expPos = 4'd0; expErr = err;
        if (err) begin
            respAt = 1;
        end else begin
            idx    = int'(addr);
            expPos = 4'(idx / 4);
            if (we) begin
                n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
                if (commit)
                    for (int j = 0; j < n; j++) gmem[idx+j] = int'((wdata >> (8*j)) & 32'hFF);
                expWdata = wordOf(idx / 4);
                if (size == 2'd2) begin
                    writeAt = 1; respAt = 2;
                end else begin
                    readAt = 1; writeAt = lat + 2; respAt = lat + 3;
                end
            end else begin
                readAt = 1;
                respAt = lat + 2;
                case (size)
                    2'd0: begin
                        v = 32'(gmem[idx]);
                        if (!uns && v >= 32'd128) v = v - 32'd256;
                    end
                    2'd1: begin
                        v = 32'(gmem[idx]) + 32'd256 * 32'(gmem[idx+1]);
                        if (!uns && v >= 32'd32768) v = v - 32'd65536;
                    end
                    default: v = wordOf(idx / 4);
                endcase
                expRdata = v;
            end
        end
        if (!commit) begin
            writeAt = NONE; respAt = NONE;
        end
        @(negedge clk);
        #1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wdata;
        bus.req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        base   = cyc - 1;
        active = 1'b1;
    endtask

    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [1:0] size,
                                 input bit uns, input logic [31:0] wdata);
        int rc0;
        rc0 = respCount;
        issue(we, addr, size, uns, wdata, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (respCount != rc0) break;
        end
        if (respCount == rc0) begin
            checks++;
            errors++;
            $display("[TB] FAIL responseTimeout got none want rsp_valid for addr 0x%08h", addr);
        end
        active = 1'b0;
    endtask

    task automatic resetDuringWait();
        lat = 4;
        issue(1'b1, 32'h14, 2'd0, 1'b0, 32'h0000_0099, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        active = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat   = 1;
    endtask

    task automatic spuriousValid();
        @(negedge clk);
        #2 spur = 1'b1;
        @(negedge clk);
        #2 spur = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        for (int w = 0; w < 16; w++)
            for (int j = 0; j < 4; j++)
                gmem[4*w+j] = int'(((32'hC0DE_0000 | 32'(w)) >> (8*j)) & 32'hFF);
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.req_wdata_i    = 32'd0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1'b1, 32'h14, 2'd2, 1'b0, 32'h1122_3344);
        checkOutput("swWrite", gotWdata, 32'h1122_3344);
        applyStimulus(1'b0, 32'h14, 2'd2, 1'b0, 32'd0);
        checkOutput("lw14", gotRdata, 32'h1122_3344);

        applyStimulus(1'b1, 32'h15, 2'd0, 1'b0, 32'hFFFF_FFAB);
        checkOutput("sbWrite", gotWdata, 32'h1122_AB44);
        applyStimulus(1'b0, 32'h15, 2'd0, 1'b0, 32'd0);
        checkOutput("lb15", gotRdata, 32'hFFFF_FFAB);
        applyStimulus(1'b0, 32'h15, 2'd0, 1'b1, 32'd0);
        checkOutput("lbu15", gotRdata, 32'h0000_00AB);

        applyStimulus(1'b1, 32'h16, 2'd1, 1'b0, 32'h0000_8001);
        checkOutput("shWrite", gotWdata, 32'h8001_AB44);
        applyStimulus(1'b0, 32'h16, 2'd1, 1'b0, 32'd0);
        checkOutput("lh16", gotRdata, 32'hFFFF_8001);
        applyStimulus(1'b0, 32'h16, 2'd1, 1'b1, 32'd0);
        checkOutput("lhu16", gotRdata, 32'h0000_8001);
        applyStimulus(1'b0, 32'h14, 2'd1, 1'b0, 32'd0);
        checkOutput("lh14", gotRdata, 32'hFFFF_AB44);

        applyStimulus(1'b0, 32'h13, 2'd2, 1'b0, 32'd0);
        checkOutput("errLwMisaligned", 32'(gotErr), 32'd1);
        applyStimulus(1'b1, 32'h17, 2'd1, 1'b0, 32'h1234);
        checkOutput("errShMisaligned", 32'(gotErr), 32'd1);
        applyStimulus(1'b0, 32'h40, 2'd2, 1'b0, 32'd0);
        checkOutput("errLwRange", 32'(gotErr), 32'd1);
        checkOutput("errLwRangeData", gotRdata, 32'd0);
        applyStimulus(1'b0, 32'h10, 2'd3, 1'b0, 32'd0);
        checkOutput("errSize", 32'(gotErr), 32'd1);

        applyStimulus(1'b1, 32'h3C, 2'd2, 1'b0, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h3C, 2'd2, 1'b0, 32'd0);
        checkOutput("lwTop", gotRdata, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h3F, 2'd0, 1'b0, 32'd0);
        checkOutput("lbLane3", gotRdata, 32'hFFFF_FFCA);
        applyStimulus(1'b0, 32'h3C, 2'd0, 1'b0, 32'd0);
        checkOutput("lbLane0", gotRdata, 32'h0000_000D);

        lat = 3;
        applyStimulus(1'b0, 32'h3E, 2'd1, 1'b1, 32'd0);
        checkOutput("lhuSlow", gotRdata, 32'h0000_CAFE);
        applyStimulus(1'b1, 32'h3D, 2'd0, 1'b0, 32'h0000_0077);
        checkOutput("sbSlowWrite", gotWdata, 32'hCAFE_770D);
        lat = 1;

        spuriousValid();
        applyStimulus(1'b0, 32'h3C, 2'd2, 1'b0, 32'd0);
        checkOutput("lwAfterSpur", gotRdata, 32'hCAFE_770D);

        resetDuringWait();
        applyStimulus(1'b0, 32'h14, 2'd2, 1'b0, 32'd0);
        checkOutput("lwAfterReset", gotRdata, 32'h8001_AB44);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
